// File: rtl/dds_par_pkg.sv
// Shared types and default timing for the DDS parallel register port engine.
package dds_par_pkg;

    localparam int DDS_BUS_W    = 8;
    localparam int DDS_HALF_CYC = 2;
    localparam int DDS_GAP_CYC  = 4;
    localparam int DDS_IOUP_CYC = 1;
    localparam int DDS_TMR_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_GAP,
        ST_IOUP,
        ST_DONE
    } dds_state_t;

endpackage

// File: rtl/dds_phase_timer.sv
// Loadable down-counter; o_last marks the final clk cycle of the loaded phase.
module dds_phase_timer
    import dds_par_pkg::*;
#(
    parameter int W = DDS_TMR_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_len,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_len - W'(1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/dds_par_port_ctrl.sv
// Command-driven engine for the DDS parallel register port: write/read
// transactions with CSB grouping, programmable PCLK/gap timing and IO_update.
module dds_par_port_ctrl
    import dds_par_pkg::*;
#(
    parameter int  MAX_BYTES  = 4,
    parameter int  WORD_BYTES = 2,
    parameter int  HALF_CYC   = DDS_HALF_CYC,
    parameter int  GAP_CYC    = DDS_GAP_CYC,
    parameter int  IOUP_CYC   = DDS_IOUP_CYC,
    localparam int NB_W       = $clog2(MAX_BYTES + 1),
    localparam int DW         = DDS_BUS_W * MAX_BYTES
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_rw,
    input  logic [NB_W-1:0]      cmd_nbytes,
    input  logic                 cmd_ioup,
    input  logic [DW-1:0]        cmd_data,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [DW-1:0]        rsp_data,
    output logic                 dds_csn,
    output logic                 dds_rwn,
    output logic                 dds_pclk,
    output logic                 dds_ioup,
    output logic [DDS_BUS_W-1:0] dds_d_o,
    output logic                 dds_d_oe,
    input  logic [DDS_BUS_W-1:0] dds_d_i
);

    localparam int GRP_W = $clog2(WORD_BYTES + 1);

    dds_state_t r_state;
    dds_state_t w_state_nxt;

    logic                 r_ready;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [DW-1:0]        r_rsp_data;
    logic                 r_csn;
    logic                 r_rwn;
    logic                 r_pclk;
    logic                 r_ioup_pin;
    logic [DDS_BUS_W-1:0] r_d_o;
    logic                 r_d_oe;

    logic                 r_rw;
    logic                 r_ioup;
    logic                 r_err;
    logic [NB_W-1:0]      r_rem;
    logic [GRP_W-1:0]     r_grp;
    logic [DW-1:0]        r_shift;
    logic [DW-1:0]        r_cap;

    logic                 w_accept;
    logic                 w_fits;
    logic                 w_legal;
    logic                 w_last;
    logic                 w_tmr_load;
    logic [DDS_TMR_W-1:0] w_tmr_len;
    logic [NB_W-1:0]      w_pad;
    logic [DW-1:0]        w_shift_init;
    logic [DW-1:0]        w_shift_nxt;
    logic [DW-1:0]        w_cap_nxt;
    logic                 w_more;

    assign w_accept = cmd_valid && r_ready;
    assign w_fits   = (cmd_nbytes <= NB_W'(MAX_BYTES));
    assign w_legal  = w_fits && ((cmd_nbytes != '0) || (cmd_ioup && !cmd_rw));

    // Left-align the active bytes so the current byte is always the top byte.
    assign w_pad        = w_fits ? (NB_W'(MAX_BYTES) - cmd_nbytes) : '0;
    assign w_shift_init = cmd_data << {w_pad, 3'b000};
    assign w_shift_nxt  = r_shift << DDS_BUS_W;
    assign w_cap_nxt    = (r_cap << DDS_BUS_W) | DW'(dds_d_i);
    assign w_more       = (r_rem > NB_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_state_nxt = ST_DONE;
                    end else if (cmd_nbytes == '0) begin
                        w_state_nxt = ST_IOUP;
                    end else begin
                        w_state_nxt = ST_SETUP;
                    end
                end
            end
            ST_SETUP: w_state_nxt = ST_LOW;
            ST_LOW: begin
                if (w_last) w_state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (w_last) begin
                    if (w_more) begin
                        w_state_nxt = (r_grp == GRP_W'(WORD_BYTES - 1)) ? ST_GAP : ST_LOW;
                    end else begin
                        w_state_nxt = r_ioup ? ST_IOUP : ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                if (w_last) w_state_nxt = ST_LOW;
            end
            ST_IOUP: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The timer is reloaded on every state change with the length of the phase being entered.
    always_comb begin
        w_tmr_load = (w_state_nxt != r_state);
        case (w_state_nxt)
            ST_LOW, ST_HIGH: w_tmr_len = DDS_TMR_W'(HALF_CYC);
            ST_GAP:          w_tmr_len = DDS_TMR_W'(GAP_CYC);
            ST_IOUP:         w_tmr_len = DDS_TMR_W'(IOUP_CYC);
            default:         w_tmr_len = DDS_TMR_W'(1);
        endcase
    end

    dds_phase_timer #(
        .W (DDS_TMR_W)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .i_load (w_tmr_load),
        .i_len  (w_tmr_len),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_csn       <= 1'b1;
            r_rwn       <= 1'b1;
            r_pclk      <= 1'b0;
            r_ioup_pin  <= 1'b0;
            r_d_o       <= '0;
            r_d_oe      <= 1'b1;
            r_rw        <= 1'b0;
            r_ioup      <= 1'b0;
            r_err       <= 1'b0;
            r_rem       <= '0;
            r_grp       <= '0;
            r_shift     <= '0;
            r_cap       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_csn       <= !((w_state_nxt == ST_LOW) || (w_state_nxt == ST_HIGH));
            r_pclk      <= (w_state_nxt == ST_HIGH);
            r_ioup_pin  <= (w_state_nxt == ST_IOUP);
            r_rsp_valid <= (w_state_nxt == ST_DONE);
            r_rsp_err   <= (w_state_nxt == ST_DONE) && (w_accept ? !w_legal : r_err);

            if (w_state_nxt == ST_IDLE) begin
                r_rwn  <= 1'b1;
                r_d_oe <= 1'b1;
                r_d_o  <= '0;
            end

            if (w_accept) begin
                r_rw    <= cmd_rw;
                r_ioup  <= cmd_ioup && !cmd_rw;
                r_err   <= !w_legal;
                r_rem   <= cmd_nbytes;
                r_grp   <= '0;
                r_shift <= w_shift_init;
                r_cap   <= '0;
                if (w_legal && (cmd_nbytes != '0)) begin
                    r_rwn  <= cmd_rw;
                    r_d_oe <= !cmd_rw;
                    r_d_o  <= cmd_rw ? '0 : w_shift_init[DW-1 -: DDS_BUS_W];
                end
            end

            if ((r_state == ST_HIGH) && w_last) begin
                if (r_rw) begin
                    r_cap <= w_cap_nxt;
                    if (!w_more) r_rsp_data <= w_cap_nxt;
                end
                if (w_more) begin
                    r_rem   <= r_rem - NB_W'(1);
                    r_shift <= w_shift_nxt;
                    r_grp   <= (r_grp == GRP_W'(WORD_BYTES - 1)) ? '0 : r_grp + GRP_W'(1);
                    if (!r_rw) r_d_o <= w_shift_nxt[DW-1 -: DDS_BUS_W];
                end
            end
        end
    end

    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign dds_csn   = r_csn;
    assign dds_rwn   = r_rwn;
    assign dds_pclk  = r_pclk;
    assign dds_ioup  = r_ioup_pin;
    assign dds_d_o   = r_d_o;
    assign dds_d_oe  = r_d_oe;

endmodule

// File: tb/tb_dds_par_port_ctrl.sv
// Directed bench for dds_par_port_ctrl: per-cycle pin traces compared to hand-computed vectors.
module tb_dds_par_port_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [2:0]  cmd_nbytes;
    logic        cmd_ioup;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic        dds_csn;
    logic        dds_rwn;
    logic        dds_pclk;
    logic        dds_ioup;
    logic [7:0]  dds_d_o;
    logic        dds_d_oe;
    logic [7:0]  dds_d_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Bit k of each trace is the pin value in cycle Tk (T0 = accept cycle).
    logic [31:0] v_csn, v_pclk, v_ioup, v_vld, v_err, v_rdy, v_rwn, v_oe;
    logic [7:0]  a_do [0:31];
    logic [31:0] a_rd [0:31];
    logic        seen_vld;

    always #5 clk = ~clk;

    dds_par_port_ctrl #(
        .MAX_BYTES  (4),
        .WORD_BYTES (2),
        .HALF_CYC   (2),
        .GAP_CYC    (4),
        .IOUP_CYC   (1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rw     (cmd_rw),
        .cmd_nbytes (cmd_nbytes),
        .cmd_ioup   (cmd_ioup),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .dds_csn    (dds_csn),
        .dds_rwn    (dds_rwn),
        .dds_pclk   (dds_pclk),
        .dds_ioup   (dds_ioup),
        .dds_d_o    (dds_d_o),
        .dds_d_oe   (dds_d_oe),
        .dds_d_i    (dds_d_i)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int k);
        v_csn[k]  = dds_csn;
        v_pclk[k] = dds_pclk;
        v_ioup[k] = dds_ioup;
        v_vld[k]  = rsp_valid;
        v_err[k]  = rsp_err;
        v_rdy[k]  = cmd_ready;
        v_rwn[k]  = dds_rwn;
        v_oe[k]   = dds_d_oe;
        a_do[k]   = dds_d_o;
        a_rd[k]   = rsp_data;
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq(tag, cmd_ready, 1'b1);
    endtask

    // Called at a negedge; that cycle becomes T0.
    task automatic issue(input logic rw, input logic [2:0] nb, input logic io, input logic [31:0] d);
        wait_ready("ready_before_issue");
        cmd_rw     = rw;
        cmd_nbytes = nb;
        cmd_ioup   = io;
        cmd_data   = d;
        cmd_valid  = 1'b1;
        v_csn = '0; v_pclk = '0; v_ioup = '0; v_vld = '0;
        v_err = '0; v_rdy = '0; v_rwn = '0; v_oe = '0;
        sample(0);
    endtask

    task automatic record(input int n, input bit drop);
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            sample(k);
            if (drop && k == 1) cmd_valid = 1'b0;
            if (k == 3) dds_d_i = 8'hA5;
            if (k == 7) dds_d_i = 8'h3C;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_rw     = 1'b0;
        cmd_nbytes = '0;
        cmd_ioup   = 1'b0;
        cmd_data   = '0;
        dds_d_i    = '0;
        repeat (3) @(negedge clk);

        check_eq("rst_ready", cmd_ready, 1'b1);
        check_eq("rst_pins", {dds_csn, dds_rwn, dds_pclk, dds_ioup, dds_d_oe}, 5'b11001);
        check_eq("rst_d_o", dds_d_o, 8'h00);
        check_eq("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
        check_eq("rst_rsp_data", rsp_data, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Four-byte write with IO_update: two CSB groups separated by a gap.
        issue(1'b0, 3'd4, 1'b1, 32'h0cd00d41);
        record(32, 1'b1);
        check_eq("wr_csn",  v_csn,  32'hFFC03C03);
        check_eq("wr_pclk", v_pclk, 32'h00330330);
        check_eq("wr_ioup", v_ioup, 32'h00400000);
        check_eq("wr_vld",  v_vld,  32'h00800000);
        check_eq("wr_err",  v_err,  32'h00000000);
        check_eq("wr_rdy",  v_rdy,  32'hFF000001);
        check_eq("wr_rwn",  v_rwn,  32'hFF000001);
        check_eq("wr_oe",   v_oe,   32'hFFFFFFFF);
        check_eq("wr_do_setup", a_do[1], 8'h0c);
        check_eq("wr_do_b0", a_do[2], 8'h0c);
        check_eq("wr_do_b1", a_do[6], 8'hd0);
        check_eq("wr_do_b2", a_do[14], 8'h0d);
        check_eq("wr_do_b3", a_do[18], 8'h41);
        check_eq("wr_do_idle", a_do[24], 8'h00);

        // Two-byte read: single group, bytes captured MSB first.
        issue(1'b1, 3'd2, 1'b0, 32'h0);
        record(32, 1'b1);
        check_eq("rd_csn",  v_csn,  32'hFFFFFC03);
        check_eq("rd_pclk", v_pclk, 32'h00000330);
        check_eq("rd_oe",   v_oe,   32'hFFFFF801);
        check_eq("rd_rwn",  v_rwn,  32'hFFFFFFFF);
        check_eq("rd_vld",  v_vld,  32'h00000400);
        check_eq("rd_do",   a_do[4], 8'h00);
        check_eq("rd_data_done", a_rd[10], 32'h0000A53C);
        check_eq("rd_data_held", a_rd[20], 32'h0000A53C);

        // Standalone IO_update.
        issue(1'b0, 3'd0, 1'b1, 32'h0);
        record(8, 1'b1);
        check_eq("iou_csn",  v_csn[7:0],  8'hFF);
        check_eq("iou_pclk", v_pclk[7:0], 8'h00);
        check_eq("iou_ioup", v_ioup[7:0], 8'h02);
        check_eq("iou_vld",  v_vld[7:0],  8'h04);
        check_eq("iou_err",  v_err[7:0],  8'h00);
        check_eq("iou_rwn",  v_rwn[7:0],  8'hFF);

        // Illegal byte counts.
        issue(1'b0, 3'd5, 1'b0, 32'hFFFFFFFF);
        record(8, 1'b1);
        check_eq("big_vld",  v_vld[7:0],  8'h02);
        check_eq("big_err",  v_err[7:0],  8'h02);
        check_eq("big_csn",  v_csn[7:0],  8'hFF);
        check_eq("big_pins", {v_pclk[7:0], v_ioup[7:0], ~v_oe[7:0], ~v_rwn[7:0]}, 32'h0);
        check_eq("big_rd_kept", a_rd[3], 32'h0000A53C);

        issue(1'b0, 3'd0, 1'b0, 32'h0);
        record(8, 1'b1);
        check_eq("zero_vld",  v_vld[7:0],  8'h02);
        check_eq("zero_err",  v_err[7:0],  8'h02);
        check_eq("zero_csn",  v_csn[7:0],  8'hFF);
        check_eq("zero_ioup", v_ioup[7:0], 8'h00);

        // Reset during the second byte of a write.
        issue(1'b0, 3'd4, 1'b0, 32'h11223344);
        record(8, 1'b1);
        rstn = 1'b0;
        #1;
        check_eq("arst_csn",   dds_csn,   1'b1);
        check_eq("arst_pclk",  dds_pclk,  1'b0);
        check_eq("arst_ready", cmd_ready, 1'b1);
        check_eq("arst_oe_rwn", {dds_d_oe, dds_rwn}, 2'b11);
        seen_vld = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_vld = seen_vld | rsp_valid;
        end
        rstn = 1'b1;
        repeat (30) begin
            @(negedge clk);
            seen_vld = seen_vld | rsp_valid;
        end
        check_eq("arst_no_vld", seen_vld, 1'b0);

        issue(1'b0, 3'd1, 1'b0, 32'h0000005A);
        record(16, 1'b1);
        check_eq("post_csn", v_csn[15:0], 16'hFFC3);
        check_eq("post_vld", v_vld[15:0], 16'h0040);
        check_eq("post_do",  a_do[2], 8'h5A);

        // cmd_valid held high: accepts only in the cycle after each rsp_valid.
        issue(1'b0, 3'd1, 1'b0, 32'h000000C3);
        record(32, 1'b0);
        cmd_valid = 1'b0;
        check_eq("b2b_rdy", v_rdy, 32'h10204081);
        check_eq("b2b_vld", v_vld, 32'h08102040);
        check_eq("b2b_csn", v_csn, 32'h3870E1C3);
        wait_ready("b2b_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_par_port_ctrl.md
Name: dds_par_port_ctrl

Overview:
- Parametrised command-driven engine for the DDS parallel register port (CSB, RWn, PCLK, IO_update, 8-bit bidirectional data).
- Replaces free-running TimeCounter-style sequencing with a valid/ready command interface.
- Adds write and read transactions, variable byte count, programmable PCLK/gap timing, read-back capture and standalone IO_update.
- Sits between VIO/sequencer logic (FreqLUT stepping, manual register access) and the JA/JB pin assigns in the top level.

Parameters:
- MAX_BYTES, 4, maximum bytes per transaction (>=1).
- WORD_BYTES, 2, bytes per CSB-low group; CSB rises between groups (>=1).
- HALF_CYC, 2, clk cycles per PCLK half-period (>=1).
- GAP_CYC, 4, clk cycles CSB held high between groups (>=1).
- IOUP_CYC, 1, clk cycles of IO_update pulse (>=1).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted when valid&&ready
- cmd_rw  in  1  1=read, 0=write
- cmd_nbytes  in  $clog2(MAX_BYTES+1)  bytes to transfer
- cmd_ioup  in  1  pulse IO_update after a write
- cmd_data  in  8*MAX_BYTES  write data, right-aligned
- rsp_valid  out  1  one-cycle completion strobe
- rsp_err  out  1  qualifies rsp_valid: illegal command
- rsp_data  out  8*MAX_BYTES  read data, right-aligned, held until next read
- dds_csn  out  1  CSB
- dds_rwn  out  1  RWn
- dds_pclk  out  1  PCLK
- dds_ioup  out  1  IO_update
- dds_d_o  out  8  data to pins
- dds_d_oe  out  1  1=drive pins, 0=tristate
- dds_d_i  in  8  data from pins

Behaviour:
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0.
  - dds_csn=1, dds_rwn=1, dds_pclk=0, dds_ioup=0, dds_d_o=0, dds_d_oe=1.
- Reset mid-transaction aborts immediately to IDLE with the reset values above; no rsp_valid is issued.
- FSM states: IDLE, SETUP, LOW, HIGH, GAP, IOUP, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept, latch the command; cmd_ready=0 from the next cycle until DONE completes.
  - cmd_valid is ignored while not ready.
- Legality:
  - nbytes>MAX_BYTES, or nbytes=0 with ioup=0: go straight to DONE with rsp_err=1; no pin activity.
  - nbytes=0 with ioup=1 is legal: go to IOUP only.
  - cmd_ioup is ignored on reads.
- SETUP (1 cycle):
  - dds_rwn=cmd_rw; dds_d_oe=~cmd_rw; csn stays 1.
  - dds_d_o = first byte on writes, 0 on reads.
- Byte order: bytes taken from cmd_data[8*nbytes-1:0], most significant first.
- LOW (HALF_CYC cycles): csn=0, pclk=0, dds_d_o=current byte (write).
- HIGH (HALF_CYC cycles):
  - csn=0, pclk=1.
  - Read: dds_d_i sampled on the clk edge ending the last HIGH cycle and shifted into the LSB of the capture register.
- After HIGH, the next state is chosen as follows:
  - More bytes remain and the group is incomplete: LOW, next byte on dds_d_o.
  - More bytes remain and WORD_BYTES bytes are done in this group: GAP (csn=1, pclk=0, GAP_CYC cycles), then LOW.
  - Last byte: write with ioup goes to IOUP; otherwise DONE.
- IOUP: csn=1, dds_ioup=1 for IOUP_CYC cycles.
- DONE (1 cycle):
  - rsp_valid=1.
  - On reads, rsp_data = captured bytes, zero-extended.
  - Then IDLE; dds_d_oe returns to 1, dds_d_o=0, dds_rwn=1.
- dds_csn is always high outside LOW/HIGH; pclk is only high in HIGH.
- Write latency from the accept edge: 1 + 2*HALF_CYC*nbytes + GAP_CYC*(ceil(nbytes/WORD_BYTES)-1) + (ioup?IOUP_CYC:0) + 1 cycles to rsp_valid.
- Back-to-back: a new command can be accepted in the cycle after rsp_valid.

Decomposition:
- Package dds_par_pkg:
  - FSM state enum.
  - Default timing constants (HALF_CYC, GAP_CYC, IOUP_CYC).
  - Bus width constant 8.
- Sub-module dds_phase_timer: loadable down-counter producing a last-cycle flag. Shared by the LOW, HIGH, GAP and IOUP phases.

Test Plan:
- Defaults; write nbytes=4, 0x0cd00d41, ioup=1, accepted at T0 -> cycles after T0:
  - csn low T2-T9 and T14-T21.
  - d_o=0x0c at T2, 0xd0 at T6, 0x0d at T14, 0x41 at T18; pclk high T4-5, T8-9, T16-17, T20-21.
  - ioup=1 at T22; rsp_valid at T23.
- Read nbytes=2 with bench driving d_i=0xA5 in byte 1 HIGH and 0x3C in byte 2 HIGH -> d_oe=0 from T1, no gap, rsp_valid at T10, rsp_data=0x0000A53C.
- nbytes=0, ioup=1 -> no csn activity; ioup high at T1; rsp_valid at T2, rsp_err=0.
- nbytes=5, then nbytes=0 with ioup=0 -> rsp_valid at T1 with rsp_err=1; pins unchanged.
- rstn low during the second byte of a write -> csn=1, pclk=0, cmd_ready=1 asynchronously; no rsp_valid; next command runs normally.
- cmd_valid held high continuously -> commands accepted only in the cycle after each rsp_valid; no overlap of csn windows.
